// File: rtl/spi_sd_pkg.sv
// Shared command codes, FSM state encoding and counter sizing for the SD-card SPI master.
// No logic of its own.
package spi_sd_pkg;

  typedef enum logic [1:0] {
    CMD_PUT  = 2'd0,
    CMD_INIT = 2'd1,
    CMD_CE0  = 2'd2,
    CMD_CE1  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int PUT_BITS = 8;

  // A PUT needs 3 bits; INIT may need more.
  function automatic int bitcnt_w(input int init_clks);
    int w;
    w = $clog2(init_clks);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Phase tick generator: tick on the last of every DIV cycles while run is high.
// Restarts from zero on each tick and whenever run drops; no backpressure.
module spi_clkdiv #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = run && (cnt == W'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || !run || tick) cnt <= '0;
    else                       cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/spi_sd.sv
// SPI mode-0 master for an SD card: byte PUT, INIT clock burst, chip-select control.
// PUT busy 16*DIV cycles, INIT 2*INIT_CLKS*DIV; strobes ignored unless idle.
module spi_sd
  import spi_sd_pkg::*;
#(
  parameter int DIV       = 2,
  parameter int INIT_CLKS = 80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi,
  input  logic [1:0] spi_ctl,
  input  logic [7:0] spi_cmd,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs
);

  localparam int CW = bitcnt_w(INIT_CLKS);

  state_e        state, state_nxt;
  cmd_e          cmd;
  logic          run, tick, is_init, last_bit, start;
  logic [7:0]    shreg, rxreg;
  logic [CW-1:0] bitcnt;

  assign cmd      = cmd_e'(spi_ctl);
  assign run      = (state == ST_LOW) || (state == ST_HIGH);
  assign busy     = run;
  assign done     = (state == ST_FIN);
  assign start    = spi && ((cmd == CMD_PUT) || (cmd == CMD_INIT));
  assign last_bit = is_init ? (bitcnt == CW'(INIT_CLKS - 1))
                            : (bitcnt == CW'(PUT_BITS - 1));

  spi_clkdiv #(.DIV(DIV)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOW;
      ST_LOW:  if (tick)  state_nxt = ST_HIGH;
      ST_HIGH: if (tick)  state_nxt = last_bit ? ST_FIN : ST_LOW;
      ST_FIN:             state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // INIT loads all-ones so the shared MOSI shift path keeps the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sd_clk  <= 1'b0;
      sd_mosi <= 1'b1;
      sd_cs   <= 1'b1;
      dout    <= 8'h00;
      shreg   <= 8'hFF;
      rxreg   <= 8'h00;
      bitcnt  <= '0;
      is_init <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spi) begin
            case (cmd)
              CMD_PUT: begin
                shreg   <= spi_cmd;
                sd_mosi <= spi_cmd[7];
                is_init <= 1'b0;
                bitcnt  <= '0;
              end
              CMD_INIT: begin
                shreg   <= 8'hFF;
                sd_mosi <= 1'b1;
                sd_cs   <= 1'b1;
                is_init <= 1'b1;
                bitcnt  <= '0;
              end
              CMD_CE0: sd_cs <= 1'b0;
              CMD_CE1: sd_cs <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_LOW: begin
          if (tick) begin
            sd_clk <= 1'b1;
            rxreg  <= {rxreg[6:0], sd_miso};
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sd_clk <= 1'b0;
            if (last_bit) begin
              sd_mosi <= 1'b1;
              if (!is_init) dout <= rxreg;
            end else begin
              sd_mosi <= shreg[6];
              shreg   <= {shreg[6:0], 1'b1};
              bitcnt  <= bitcnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sd.sv
// Directed + randomized bench for spi_sd with a behavioural SD-card MISO model.
module tb_spi_sd;

  localparam int DIV       = 2;
  localparam int INIT_CLKS = 80;
  localparam int PUT_CYC   = 16 * DIV;
  localparam int INIT_CYC  = 2 * INIT_CLKS * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       spi = 1'b0;
  logic [1:0] spi_ctl = 2'd0;
  logic [7:0] spi_cmd = 8'h00;
  logic [7:0] dout;
  logic       busy, done, sd_clk, sd_mosi, sd_miso, sd_cs;

  int n_asserts = 0;
  int n_fail    = 0;

  spi_sd #(.DIV(DIV), .INIT_CLKS(INIT_CLKS)) dut (
    .clock   (clock),
    .reset   (reset),
    .spi     (spi),
    .spi_ctl (spi_ctl),
    .spi_cmd (spi_cmd),
    .dout    (dout),
    .busy    (busy),
    .done    (done),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs   (sd_cs)
  );

  always #5 clock = ~clock;

  // Card model: presents response bit 7-k before the k-th rising sd_clk.
  logic [7:0] miso_byte = 8'h00;
  int         miso_idx  = 0;
  assign sd_miso = (miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b1;
  always @(posedge sd_clk) miso_idx++;

  // Bus monitor, sampled on the falling system clock edge.
  logic       prev_clk  = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  logic       mosi_q[$];
  logic       cs_q[$];
  int         busy_cyc = 0;
  int         done_cnt = 0;
  int         dout_bad = 0;

  always @(negedge clock) begin
    if (sd_clk && !prev_clk) begin
      mosi_q.push_back(sd_mosi);
      cs_q.push_back(sd_cs);
    end
    prev_clk = sd_clk;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (dout !== prev_dout && !done && !reset) dout_bad++;
    prev_dout = dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats(input logic [7:0] resp);
    mosi_q.delete();
    cs_q.delete();
    busy_cyc  = 0;
    done_cnt  = 0;
    dout_bad  = 0;
    miso_byte = resp;
    miso_idx  = 0;
  endtask

  // Called at posedge+1; the pulse is seen by exactly one rising edge.
  task automatic strobe(input logic [1:0] ctl, input logic [7:0] cmd);
    spi = 1'b1; spi_ctl = ctl; spi_cmd = cmd;
    @(posedge clock); #1;
    spi = 1'b0;
  endtask

  // Returns in the idle cycle following the done pulse.
  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_done_seen"}, 32'(k < budget), 1);
    check({tag, "_busy_low_at_done"}, 32'(busy), 0);
    @(posedge clock); #1;
  endtask

  function automatic logic [7:0] mosi_byte();
    logic [7:0] b;
    b = 8'h00;
    foreach (mosi_q[i]) b = {b[6:0], mosi_q[i]};
    return b;
  endfunction

  task automatic run_put(input logic [7:0] cmd, input logic [7:0] resp, input string tag);
    clear_stats(resp);
    strobe(2'd0, cmd);
    wait_done(4 * PUT_CYC, tag);
    check({tag, "_rises"}, mosi_q.size(), 8);
    check({tag, "_mosi"}, mosi_byte(), cmd);
    check({tag, "_dout"}, dout, resp);
    check({tag, "_busy_cyc"}, busy_cyc, PUT_CYC);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_dout_stable"}, dout_bad, 0);
    check({tag, "_idle_bus"}, {29'd0, sd_clk, sd_mosi, done}, 32'b010);
  endtask

  initial begin
    int   k;
    int   bad;
    logic [7:0] c, r, keep;

    // Reset, with a strobe coincident with reset that must be dropped.
    repeat (2) @(posedge clock);
    #1;
    spi = 1'b1; spi_ctl = 2'd0; spi_cmd = 8'h55;
    @(posedge clock); #1;
    spi = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_sd_clk", sd_clk, 0);
    check("rst_sd_mosi", sd_mosi, 1);
    check("rst_sd_cs", sd_cs, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 8'h00);

    // Chip-select commands.
    clear_stats(8'h00);
    strobe(2'd2, 8'h00);
    check("ce0_cs", sd_cs, 0);
    strobe(2'd3, 8'h00);
    check("ce1_cs", sd_cs, 1);
    repeat (2) @(posedge clock);
    #1;
    check("ce_busy_cyc", busy_cyc, 0);
    check("ce_done_cnt", done_cnt, 0);

    // Reference byte exchange.
    strobe(2'd2, 8'h00);
    run_put(8'hA5, 8'h3C, "put_a5");
    bad = 0;
    foreach (cs_q[i]) if (cs_q[i] !== 1'b0) bad++;
    check("put_a5_cs_low", bad, 0);

    // INIT while CS is low: CS forced high, MOSI high, dout kept.
    keep = dout;
    clear_stats(8'h00);
    strobe(2'd1, 8'h00);
    wait_done(4 * INIT_CYC, "init");
    check("init_rises", mosi_q.size(), INIT_CLKS);
    bad = 0;
    foreach (mosi_q[i]) if (mosi_q[i] !== 1'b1 || cs_q[i] !== 1'b1) bad++;
    check("init_cs_mosi_high", bad, 0);
    check("init_busy_cyc", busy_cyc, INIT_CYC);
    check("init_done_cnt", done_cnt, 1);
    check("init_dout", dout, keep);
    repeat (5) @(posedge clock);
    #1;
    check("init_cs_held", sd_cs, 1);

    // Random PUTs, issued back-to-back in the cycle after FIN.
    strobe(2'd2, 8'h00);
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom);
      r = 8'($urandom);
      run_put(c, r, $sformatf("rnd%0d", i));
    end

    // Second PUT strobed mid-transfer must be ignored.
    r = 8'($urandom);
    clear_stats(r);
    strobe(2'd0, 8'hFF);
    k = 0;
    while (mosi_q.size() < 3 && k < 4 * PUT_CYC) begin
      @(posedge clock); #1;
      k++;
    end
    check("ign_reach_bit3", 32'(k < 4 * PUT_CYC), 1);
    strobe(2'd0, 8'h00);
    wait_done(4 * PUT_CYC, "ign");
    check("ign_mosi", mosi_byte(), 8'hFF);
    check("ign_rises", mosi_q.size(), 8);
    check("ign_dout", dout, r);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_busy_cyc", busy_cyc, PUT_CYC);
    repeat (3) @(posedge clock);
    #1;
    check("ign_no_restart", busy, 0);

    // Reset at the 5th sd_clk rise, then a clean transfer.
    clear_stats(8'h77);
    strobe(2'd0, 8'h3E);
    k = 0;
    while (miso_idx < 5 && k < 4 * PUT_CYC) begin
      @(posedge clock); #1;
      k++;
    end
    check("mid_reach_rise5", 32'(k < 4 * PUT_CYC), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_bus", {27'd0, sd_clk, sd_cs, sd_mosi, busy, done}, 32'b01100);
    check("mid_rst_dout", dout, 8'h00);
    reset = 1'b0;
    @(posedge clock); #1;
    strobe(2'd2, 8'h00);
    r = 8'($urandom);
    run_put(8'h81, r, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sd.md
SPI_SD -- requirements
Module: spi_sd

Interface
REQ-001 Parameter: DIV, 2, SD_CLK half-period in clock cycles (>=1); SD_CLK = clock/(2*DIV).
REQ-002 Parameter: INIT_CLKS, 80, SD_CLK pulses issued by the INIT command.
REQ-003 Port: clock  in  1  system clock (25 MHz domain); single clock domain.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: spi  in  1  command strobe, one-cycle pulse from the port controller.
REQ-006 Port: spi_ctl  in  2  command code: 0 PUT, 1 INIT, 2 CE0 (CS low), 3 CE1 (CS high).
REQ-007 Port: spi_cmd  in  8  byte to transmit for PUT.
REQ-008 Port: dout  out  8  last byte received from MISO.
REQ-009 Port: busy  out  1  transfer (PUT/INIT) in progress.
REQ-010 Port: done  out  1  one-cycle pulse on PUT/INIT completion.
REQ-011 Port: sd_clk  out  1  SPI clock to SD_CLK.
REQ-012 Port: sd_mosi  out  1  SPI data out to SD_CMD.
REQ-013 Port: sd_miso  in  1  SPI data in from SD_DATA[0].
REQ-014 Port: sd_cs  out  1  chip select to SD_DATA[3], active low.

Function
REQ-015 The block SHALL implement SPI mode 0, MSB first: sd_clk idle low, MISO sampled on sd_clk rising edge, MOSI updated on falling edge.
REQ-016 The FSM SHALL have states IDLE, LOW (sd_clk=0 phase), HIGH (sd_clk=1 phase), FIN.
REQ-017 In IDLE, spi=1 SHALL be accepted; spi while busy=1 or in FIN SHALL be ignored with no side effects.
REQ-018 PUT: on accept, load spi_cmd into shift register, drive sd_mosi=spi_cmd[7], enter LOW, busy=1 from next cycle.
REQ-019 Each LOW and HIGH phase SHALL last exactly DIV cycles, counted by a divider counter reset on every phase change.
REQ-020 LOW->HIGH: sd_clk rises, sd_miso shifted into receive register LSB; HIGH->LOW: sd_clk falls, sd_mosi advances to next bit.
REQ-021 After the 8th HIGH phase the FSM SHALL enter FIN with sd_clk=0, dout updated with the received byte, done=1 for that one cycle, busy=0 in that same cycle, then IDLE.
REQ-022 PUT busy duration SHALL be exactly 16*DIV cycles; dout changes only in the FIN cycle.
REQ-023 INIT: force sd_cs=1 and sd_mosi=1 for the whole transfer, issue INIT_CLKS sd_clk pulses, busy duration 2*INIT_CLKS*DIV cycles, done at end; dout unchanged.
REQ-024 After INIT, sd_cs SHALL remain 1 until a CE0 command.
REQ-025 CE0/CE1: set sd_cs to 0/1 on the cycle after the strobe; busy and done SHALL not assert.
REQ-026 Between transfers sd_mosi SHALL be 1 and sd_clk 0.
REQ-027 A strobe arriving in the cycle after FIN (IDLE) SHALL be accepted; back-to-back PUTs are separated by at least one idle cycle.
REQ-028 Bit counter SHALL be 3 bits for PUT and wide enough for INIT_CLKS (7 bits at default); no wrap observable beyond the terminal count.

Reset
REQ-029 On reset=1 (any state, including mid-transfer) at the next clock edge: state IDLE, sd_clk=0, sd_mosi=1, sd_cs=1, busy=0, done=0, dout=8'h00, counters cleared.
REQ-030 A strobe coincident with reset SHALL be discarded.

Structure
REQ-031 Package spi_sd_pkg SHALL hold command codes (PUT/INIT/CE0/CE1) and the FSM state encoding.
REQ-032 One sub-module spi_clkdiv (DIV-cycle phase tick generator) is natural; the rest is a single FSM.
REQ-033 Estimated size 150-250 lines RTL.

Verification
REQ-034 DIV=2, PUT 0xA5, MISO model returns 0x3C -> MOSI at rising edges 1,0,1,0,0,1,0,1; dout=0x3C; busy high 32 cycles; single done pulse.
REQ-035 INIT -> exactly 80 sd_clk rising edges with sd_cs=1, sd_mosi=1; busy 320 cycles (DIV=2); dout unchanged.
REQ-036 CE0 then CE1 -> sd_cs 0 one cycle after first strobe, 1 one cycle after second; busy/done stay 0.
REQ-037 PUT 0xFF, second PUT 0x00 strobed at bit 3 -> second ignored, MOSI all 1, one done pulse.
REQ-038 reset asserted at 5th sd_clk rise of PUT -> next cycle sd_clk=0, sd_cs=1, sd_mosi=1, busy=0, dout=0x00; subsequent PUT 0x81 completes normally.
REQ-039 PUT strobed the cycle after done -> accepted; two complete transfers, correct dout each.
